// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 tristate mux channel.
// Grants one requester at a time and inserts a dead gap after every ownership change.
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int GAP      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       bus_en,
   output logic       busy,
   output logic       timeout
);

   // state   | meaning
   // S_IDLE  | channel free, arbitrate on any request
   // S_GRANT | sel owns the channel, bus driven, hold timer running
   // S_GAP   | no driver; dead cycles before the next arbitration
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(MAX_HOLD - 1);
   localparam logic [1:0] GAP_LOAD  = 2'(GAP - 1);

   state_t     state, state_nxt;
   logic [3:0] hold_cnt, hold_nxt;
   logic [1:0] gap_cnt, gap_nxt;
   logic [1:0] last, last_nxt;
   logic [3:0] grant_nxt;
   logic [1:0] sel_nxt;
   logic       bus_en_nxt, busy_nxt, timeout_nxt;

   logic       win_vld;
   logic [1:0] win_idx;
   logic [1:0] cand;
   logic       own_req, own_done, hold_tc, rel;

   // Search starts one past the last owner; i=4 wraps to the last owner itself.
   always_comb begin
      win_vld = 1'b0;
      win_idx = last;
      cand    = last;
      for (int i = 1; i <= 4; i++) begin
         cand = last + 2'(i);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign own_req  = req[sel];
   assign own_done = done[sel];
   assign hold_tc  = (hold_cnt == 4'd0);
   assign rel      = !own_req || own_done || hold_tc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         hold_cnt <= 4'd0;
         gap_cnt  <= 2'd0;
         last     <= 2'd3;
         grant    <= 4'd0;
         sel      <= 2'd0;
         bus_en   <= 1'b0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         gap_cnt  <= gap_nxt;
         last     <= last_nxt;
         grant    <= grant_nxt;
         sel      <= sel_nxt;
         bus_en   <= bus_en_nxt;
         busy     <= busy_nxt;
         timeout  <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (win_vld) state_nxt = S_GRANT;
         S_GRANT: if (rel) state_nxt = S_GAP;
         S_GAP:   if (gap_cnt == 2'd0) state_nxt = win_vld ? S_GRANT : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      hold_nxt    = hold_cnt;
      gap_nxt     = gap_cnt;
      last_nxt    = last;
      grant_nxt   = grant;
      sel_nxt     = sel;
      bus_en_nxt  = bus_en;
      busy_nxt    = busy;
      timeout_nxt = 1'b0;
      if (state != S_GRANT && state_nxt == S_GRANT) begin
         grant_nxt  = 4'b0001 << win_idx;
         sel_nxt    = win_idx;
         bus_en_nxt = 1'b1;
         busy_nxt   = 1'b1;
         hold_nxt   = HOLD_LOAD;
      end else if (state == S_GRANT && state_nxt == S_GRANT) begin
         hold_nxt = hold_cnt - 4'd1;
      end else if (state == S_GRANT && state_nxt == S_GAP) begin
         // grant and bus_en fall together so the tristate driver never outlives ownership
         grant_nxt   = 4'd0;
         bus_en_nxt  = 1'b0;
         busy_nxt    = 1'b1;
         last_nxt    = sel;
         gap_nxt     = GAP_LOAD;
         timeout_nxt = hold_tc && own_req && !own_done;
      end else if (state == S_GAP && state_nxt == S_GAP) begin
         gap_nxt = gap_cnt - 2'd1;
      end else if (state_nxt == S_IDLE) begin
         grant_nxt  = 4'd0;
         bus_en_nxt = 1'b0;
         busy_nxt   = 1'b0;
      end
   end

endmodule
